// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry sync FIFO and its read-side stream engine.
package fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 8;

  typedef logic [FIFO_DW-1:0] fifo_data_t;

  // Pointer width for a ring of 'depth' entries; a single-entry ring still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small register-based FIFO that catches words arriving one cycle after the FIFO read strobe.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = 2,
  localparam int PW   = ptr_w(DEPTH),
  localparam int OW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [OW-1:0] occ
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign pop_ok  = pop && (occ != '0);
  assign push_ok = push && ((occ != OW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared too, so the head (and therefore m_data) reads 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the sync FIFO into a valid/ready stream, hiding the FIFO's one-cycle read latency.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DW         = FIFO_DW,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_data,
  output logic             fifo_rd,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             busy,
  output logic [CNT_W-1:0] words_cnt
);

  localparam int OW = $clog2(SKID_DEPTH + 1);

  logic          pend;
  logic [OW-1:0] occ;
  logic          pop;
  logic [OW:0]   occ_after;

  assign pop = m_valid && m_ready;

  // Occupancy once this cycle's capture and pop have landed; a new read only goes out
  // when its word is guaranteed a free slot on arrival.
  assign occ_after = {1'b0, occ} + (OW+1)'(pend) - (OW+1)'(pop);
  assign fifo_rd   = !rst && en && !fifo_empty && (occ_after < (OW+1)'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pend      <= 1'b0;
      words_cnt <= '0;
    end else begin
      pend <= fifo_rd;
      if (pop) words_cnt <= words_cnt + CNT_W'(1);
    end
  end

  fifo_skid_buf #(
    .DW    (DW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (pend),
    .push_data (fifo_data),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != '0);
  assign busy    = pend || m_valid;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: FIFO + stream-sink environment with a queue-based reference model.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  fifo_data_t fifo_data;
  logic       fifo_rd;
  logic       m_valid;
  logic       m_ready;
  fifo_data_t m_data;
  logic       busy;
  logic [15:0] words_cnt;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DW(8), .SKID_DEPTH(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .words_cnt  (words_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO's contents, and every word read out of it but not yet
  // delivered, tagged with the clock edge at which the FIFO handed it over.
  typedef struct {
    fifo_data_t d;
    int         e;
  } word_t;

  fifo_data_t fifo_q[$];
  word_t      exp_q[$];
  int         cyc        = 0;
  int         pops_total = 0;
  int         rd_total   = 0;
  logic       act_rd;
  logic       act_pop;

  task automatic load(input fifo_data_t d);
    if (fifo_q.size() < FIFO_DEPTH) fifo_q.push_back(d);
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // Sample just before the coming edge and compare against the model's rules.
  task automatic settle_and_check();
    logic exp_valid, exp_pop, exp_rd;
    #1;
    act_rd  = fifo_rd;
    act_pop = m_valid && m_ready && !rst;
    if (rst) begin
      check("rd_in_reset", fifo_rd, 0);
    end else begin
      exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].e + 1);
      exp_pop   = exp_valid && m_ready;
      exp_rd    = en && (fifo_q.size() > 0) && ((exp_q.size() - int'(exp_pop)) < 2);
      check("fifo_rd", fifo_rd, exp_rd);
      check("m_valid", m_valid, exp_valid);
      if (exp_valid) check("m_data", m_data, exp_q[0].d);
      check("busy", busy, exp_q.size() != 0);
      check("words_cnt", words_cnt, pops_total[15:0]);
      check("outstanding_le_2", exp_q.size() <= 2, 1);
      if (act_rd) rd_total++;
      if (act_pop && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pops_total++;
      end
    end
  endtask

  task automatic advance();
    fifo_data_t w;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      fifo_q.delete();
      pops_total = 0;
      fifo_data  = '0;
    end else if (act_rd && fifo_q.size() > 0) begin
      w         = fifo_q.pop_front();
      fifo_data = w;
      exp_q.push_back('{d: w, e: cyc});
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic step();
    settle_and_check();
    advance();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_seq8();
    for (int i = 0; i < 8; i++) load(8'h11 + 8'(i));
  endtask

  typedef struct {
    logic       en;
    logic       rdy;
    logic       rd;
    logic       vld;
    logic       bsy;
    fifo_data_t data;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    int k;
    bit seen_ffff;

    for (int i = 0; i < 11; i++) begin
      tbl[i].en   = 1'b1;
      tbl[i].rdy  = 1'b1;
      tbl[i].rd   = (i < 8);
      tbl[i].vld  = (i >= 2) && (i <= 9);
      tbl[i].bsy  = (i >= 1) && (i <= 9);
      tbl[i].data = 8'h11 + 8'(i - 2);
    end

    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;

    // Reset state, then a full 8-word drain at one word per clock.
    do_reset();
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_busy", busy, 0);
    check("reset_words_cnt", words_cnt, 0);
    check("reset_fifo_rd", fifo_rd, 0);
    load_seq8();
    rd0 = rd_total;
    for (int i = 0; i < 11; i++) begin
      en      = tbl[i].en;
      m_ready = tbl[i].rdy;
      settle_and_check();
      check($sformatf("t1_rd[%0d]", i), act_rd, tbl[i].rd);
      check($sformatf("t1_valid[%0d]", i), m_valid, tbl[i].vld);
      if (tbl[i].vld) check($sformatf("t1_data[%0d]", i), m_data, tbl[i].data);
      check($sformatf("t1_busy[%0d]", i), busy, tbl[i].bsy);
      advance();
    end
    #1;
    check("t1_words_cnt", words_cnt, 8);
    check("t1_reads", rd_total - rd0, 8);

    // Sink stalled: only two reads fit, head holds 0x11; release keeps order.
    do_reset();
    load_seq8();
    en = 1'b1; m_ready = 1'b0;
    rd0 = rd_total;
    repeat (6) step();
    check("t2_reads_stalled", rd_total - rd0, 2);
    #1;
    check("t2_hold_valid", m_valid, 1);
    check("t2_hold_data", m_data, 8'h11);
    m_ready = 1'b1;
    k = 0;
    while (k < 40 && (fifo_q.size() != 0 || exp_q.size() != 0)) begin step(); k++; end
    check("t2_drained", (fifo_q.size() == 0) && (exp_q.size() == 0), 1);
    #1;
    check("t2_words_cnt", words_cnt, 8);

    // Alternating ready.
    do_reset();
    load_seq8();
    en = 1'b1;
    k = 0;
    while (k < 60 && (fifo_q.size() != 0 || exp_q.size() != 0)) begin
      m_ready = (k % 2 == 0);
      step();
      k++;
    end
    check("t3_drained", (fifo_q.size() == 0) && (exp_q.size() == 0), 1);
    #1;
    check("t3_words_cnt", words_cnt, 8);

    // Enable dropped one cycle after the first read: the in-flight word still arrives.
    do_reset();
    load_seq8();
    en = 1'b1; m_ready = 1'b1;
    rd0 = rd_total;
    step();
    en = 1'b0;
    repeat (6) step();
    check("t4_reads", rd_total - rd0, 1);
    #1;
    check("t4_busy", busy, 0);
    check("t4_words_cnt", words_cnt, 1);

    // Reset while a word is waiting.
    do_reset();
    load_seq8();
    en = 1'b1; m_ready = 1'b0;
    repeat (3) step();
    #1;
    check("t5_valid_before", m_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t5_valid_after", m_valid, 0);
    check("t5_words_cnt", words_cnt, 0);
    check("t5_fifo_rd", fifo_rd, 0);
    check("t5_m_data", m_data, 0);

    // Empty FIFO with enable high: never a read.
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    rd0 = rd_total;
    repeat (10) step();
    check("t6_no_reads", rd_total - rd0, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0) load(8'($urandom));
      en      = ($urandom_range(0, 7) != 0);
      m_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      step();
    end

    // Counter wrap at 2^16 delivered words.
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    seen_ffff = 1'b0;
    k = 0;
    while (k < 70000 && pops_total < 65536) begin
      load(8'(k));
      step();
      if (pops_total == 65535 && !seen_ffff) begin
        #1;
        check("wrap_ffff", words_cnt, 16'hFFFF);
        seen_ffff = 1'b1;
      end
      k++;
    end
    check("wrap_reached", pops_total >= 65536, 1);
    #1;
    check("wrap_zero", words_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
